// File: rtl/grf_mp.sv
// Multi-port general register file: NREAD combinational read ports, two write ports
// (port 1 wins), write-first bypass and a per-register pending-write scoreboard.
// Optional write trace under GRF_MP_TRACE_EN.
module grf_mp #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2,
  parameter int PW    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD*DW-1:0] rd_data,
  output logic [NREAD-1:0]    rd_pend,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [DW-1:0]       wdata0,
  input  logic                wclr0,
  input  logic [31:0]         pc0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [DW-1:0]       wdata1,
  input  logic                wclr1,
  input  logic [31:0]         pc1,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_full,
  output logic                sb_err
);

  localparam int NREG = 2 ** AW;
  localparam int CMAX = 2 ** PW - 1;

  logic [DW-1:0] regs    [NREG];
  logic [PW-1:0] cnt     [NREG];
  logic [PW-1:0] cntNext [NREG];
  logic          cntErr;
  logic [AW-1:0] rdA;
  int            pendCnt;

  // Net change of -2..+1 is resolved in one step so saturation and clamping see the true sum.
  always_comb begin
    cntErr = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin : g_next
      int s;
      s = int'(cnt[r])
        + int'(iss_en && iss_addr == AW'(r))
        - int'(we0 && wclr0 && waddr0 == AW'(r))
        - int'(we1 && wclr1 && waddr1 == AW'(r));
      cntNext[r] = cnt[r];
      if (r != 0) begin
        if (s > CMAX) begin
          cntNext[r] = PW'(CMAX);
          cntErr     = 1'b1;
        end else if (s < 0) begin
          cntNext[r] = '0;
          cntErr     = 1'b1;
        end else begin
          cntNext[r] = PW'(s);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (we0 && waddr0 != '0) regs[waddr0] <= wdata0;
      if (we1 && waddr1 != '0) regs[waddr1] <= wdata1;
      for (int unsigned i = 0; i < NREG; i++) cnt[i] <= cntNext[i];
      if (cntErr) sb_err <= 1'b1;
    end
  end

  // A register retiring this cycle reads as not pending since its data is on the bypass.
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    rdA     = '0;
    pendCnt = 0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      rdA = rd_addr[k*AW +: AW];
      if (rdA == '0) begin
        rd_data[k*DW +: DW] = '0;
      end else if (we1 && waddr1 == rdA) begin
        rd_data[k*DW +: DW] = wdata1;
      end else if (we0 && waddr0 == rdA) begin
        rd_data[k*DW +: DW] = wdata0;
      end else begin
        rd_data[k*DW +: DW] = regs[rdA];
      end
      pendCnt = int'(cnt[rdA])
              - int'(we0 && wclr0 && waddr0 == rdA)
              - int'(we1 && wclr1 && waddr1 == rdA);
      rd_pend[k] = (rdA != '0) && (pendCnt > 0);
    end
  end

  assign iss_full = (cnt[iss_addr] == PW'(CMAX)) && (iss_addr != '0);

`ifdef GRF_MP_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (we0) $display("@%h: $%0d <= %h", pc0, waddr0, wdata0);
      if (we1) $display("@%h: $%0d <= %h", pc1, waddr1, wdata1);
    end
  end
`else
  logic unusedPc;
  assign unusedPc = ^{pc0, pc1};
`endif

endmodule
